// File: rtl/alu_pkg.sv
// Shared opcode encodings and condition-code bit positions for the RISC-Mini ALU.
// Opcode layout is {func[3:0], type[2:0]}.
package alu_pkg;

  typedef enum logic [2:0] {
    R_TYPE = 3'b000,
    I_TYPE = 3'b001,
    M_TYPE = 3'b010,
    B_TYPE = 3'b011,
    J_TYPE = 3'b100
  } op_type_e;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    MULT = 4'd2,
    AND  = 4'd3,
    OR   = 4'd4,
    XOR  = 4'd5,
    NOT  = 4'd6
  } r_func_e;

  typedef enum logic [3:0] {
    BEQ = 4'd0,
    BNE = 4'd1,
    BLT = 4'd2,
    BLE = 4'd3,
    BGT = 4'd4,
    BGE = 4'd5
  } b_func_e;

  localparam int CC_TAKEN  = 0;
  localparam int CC_OVF    = 1;
  localparam int CC_BORROW = 2;
  localparam int CC_W      = 4;

endpackage

// File: rtl/alu_if.sv
// Operand/opcode inputs and registered result/condition codes of the ALU.
// No handshake: the ALU samples a, b, opcode on every rising clk edge and
// presents the result one cycle later; a new operation may be issued each cycle.
interface alu_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [6:0]       opcode;
  logic [WIDTH-1:0] alu_out;
  logic [3:0]       alu_cc;

  modport master (output a, output b, output opcode, input alu_out, input alu_cc);
  modport slave  (input a, input b, input opcode, output alu_out, output alu_cc);
endinterface

// File: rtl/alu_comb.sv
// Combinational ALU datapath: decodes the opcode and produces the next
// result and condition codes for the output register.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [6:0]       opcode_i,
  output logic [WIDTH-1:0] out_o,
  output logic [CC_W-1:0]  cc_o
);

  op_type_e         op_type;
  r_func_e          r_func;
  b_func_e          b_func;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] prod;
  logic             a_msb;
  logic             b_msb;
  logic             eq;
  logic             slt;
  logic             ult;

  assign op_type = op_type_e'(opcode_i[2:0]);
  assign r_func  = r_func_e'(opcode_i[6:3]);
  assign b_func  = b_func_e'(opcode_i[6:3]);

  // Low WIDTH bits of the product are the same for signed and unsigned operands.
  assign sum   = a_i + b_i;
  assign diff  = a_i - b_i;
  assign prod  = a_i * b_i;
  assign a_msb = a_i[WIDTH-1];
  assign b_msb = b_i[WIDTH-1];
  assign eq    = (a_i == b_i);
  assign slt   = ($signed(a_i) < $signed(b_i));
  assign ult   = (a_i < b_i);

  always_comb begin
    out_o = '0;
    cc_o  = '0;
    case (op_type)
      R_TYPE: begin
        case (r_func)
          ADD: begin
            out_o         = sum;
            cc_o[CC_OVF]  = (a_msb & b_msb & ~sum[WIDTH-1]) |
                            (~a_msb & ~b_msb & sum[WIDTH-1]);
          end
          SUB: begin
            out_o           = diff;
            cc_o[CC_OVF]    = (a_msb ^ b_msb) & (a_msb ^ diff[WIDTH-1]);
            cc_o[CC_BORROW] = ult;
          end
          MULT:    out_o = prod;
          AND:     out_o = a_i & b_i;
          OR:      out_o = a_i | b_i;
          XOR:     out_o = a_i ^ b_i;
          NOT:     out_o = ~a_i;
          default: out_o = '0;
        endcase
      end
      B_TYPE: begin
        case (b_func)
          BEQ:     cc_o[CC_TAKEN] = eq;
          BNE:     cc_o[CC_TAKEN] = ~eq;
          BLT:     cc_o[CC_TAKEN] = slt;
          BLE:     cc_o[CC_TAKEN] = slt | eq;
          BGT:     cc_o[CC_TAKEN] = ~(slt | eq);
          BGE:     cc_o[CC_TAKEN] = ~slt;
          default: cc_o[CC_TAKEN] = 1'b0;
        endcase
      end
      default: begin
        out_o = '0;
        cc_o  = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_core.sv
// Execute-stage ALU: combinational datapath followed by a result/condition-code
// register that loads every cycle and clears asynchronously on rst.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  alu_if.slave bus
);

  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic [CC_W-1:0]  cc_d;
  logic [CC_W-1:0]  cc_q;

  alu_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a_i      (bus.a),
    .b_i      (bus.b),
    .opcode_i (bus.opcode),
    .out_o    (out_d),
    .cc_o     (cc_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
      cc_q  <= '0;
    end else begin
      out_q <= out_d;
      cc_q  <= cc_d;
    end
  end

  assign bus.alu_out = out_q;
  assign bus.alu_cc  = cc_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed scenarios plus a back-to-back
// random run, all scored through an expected queue of {out, cc}.
module tb_alu_core;
  import alu_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [W+3:0] exp_q[$];

  alu_if #(.WIDTH(W)) bus ();

  alu_core #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] mk_op(input logic [3:0] func, input logic [2:0] typ);
    return {func, typ};
  endfunction

  // Independent reference: overflow from 64-bit signed arithmetic, borrow from 33-bit subtract.
  function automatic logic [W+3:0] golden(input logic [31:0] a, input logic [31:0] b,
                                           input logic [6:0] op);
    logic [31:0] o;
    logic [3:0]  c;
    longint      sa, sb, s;
    logic [32:0] d;
    logic [63:0] p;
    o  = '0;
    c  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op[2:0] == 3'd0) begin
      case (op[6:3])
        4'd0: begin
          o = a + b;
          s = sa + sb;
          c[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        4'd1: begin
          o = a - b;
          s = sa - sb;
          c[1] = (s > 64'sd2147483647) || (s < -64'sd2147483648);
          d = {1'b0, a} - {1'b0, b};
          c[2] = d[32];
        end
        4'd2: begin
          p = {32'd0, a} * {32'd0, b};
          o = p[31:0];
        end
        4'd3: o = a & b;
        4'd4: o = a | b;
        4'd5: o = a ^ b;
        4'd6: o = ~a;
        default: o = '0;
      endcase
    end else if (op[2:0] == 3'd3) begin
      case (op[6:3])
        4'd0: c[0] = (a == b);
        4'd1: c[0] = (a != b);
        4'd2: c[0] = (sa < sb);
        4'd3: c[0] = (sa <= sb);
        4'd4: c[0] = (sa > sb);
        4'd5: c[0] = (sa >= sb);
        default: c[0] = 1'b0;
      endcase
    end
    return {o, c};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [6:0] op,
                       input logic [W+3:0] exp);
    @(negedge clk);
    bus.a      = a;
    bus.b      = b;
    bus.opcode = op;
    exp_q.push_back(exp);
  endtask

  // Runs a directed list: each entry issued, clocked once, popped and compared.
  task automatic run_list(input string name, input logic [31:0] av[], input logic [31:0] bv[],
                          input logic [6:0] ov[], input logic [W+3:0] ev[]);
    logic [W+3:0] exp;
    for (int i = 0; i < ov.size(); i++) begin
      issue(av[i], bv[i], ov[i], ev[i]);
      @(posedge clk);
      #1;
      exp = exp_q.pop_front();
      checks++;
      if ({bus.alu_out, bus.alu_cc} !== exp) begin
        errors++;
        $display("FAIL %s[%0d] op=%h a=%h b=%h: got out=%h cc=%b, want out=%h cc=%b",
                 name, i, ov[i], av[i], bv[i], bus.alu_out, bus.alu_cc, exp[W+3:4], exp[3:0]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.a      = 32'hDEAD_BEEF;
    bus.b      = 32'h1234_5678;
    bus.opcode = mk_op(4'd0, 3'd0);
    rst        = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.alu_out !== 32'd0 || bus.alu_cc !== 4'd0) begin
      errors++;
      $display("FAIL reset: got out=%h cc=%b, want 0/0000", bus.alu_out, bus.alu_cc);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    run_list("add",
             '{32'd5, 32'h7FFF_FFFF},
             '{32'd7, 32'd1},
             '{mk_op(4'd0, 3'd0), mk_op(4'd0, 3'd0)},
             '{{32'd12, 4'b0000}, {32'h8000_0000, 4'b0010}});
  endtask

  task automatic test_sub();
    run_list("sub",
             '{32'd0, 32'h8000_0000, 32'd9},
             '{32'd1, 32'd1, 32'd4},
             '{mk_op(4'd1, 3'd0), mk_op(4'd1, 3'd0), mk_op(4'd1, 3'd0)},
             '{{32'hFFFF_FFFF, 4'b0100}, {32'h7FFF_FFFF, 4'b0010}, {32'd5, 4'b0000}});
  endtask

  task automatic test_logic();
    run_list("logic",
             '{32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'hFFFF_FFFF},
             '{32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'd2},
             '{mk_op(4'd3, 3'd0), mk_op(4'd4, 3'd0), mk_op(4'd5, 3'd0), mk_op(4'd6, 3'd0),
               mk_op(4'd2, 3'd0)},
             '{{32'h0204_0608, 4'b0}, {32'h1F3F_5F7F, 4'b0}, {32'h1D3B_5977, 4'b0},
               {32'hEDCB_A987, 4'b0}, {32'hFFFF_FFFE, 4'b0}});
  endtask

  task automatic test_branch();
    run_list("branch",
             '{32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h1234,
               32'h8000_0000, 32'h8000_0000},
             '{32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'h1234, 32'd0, 32'd0},
             '{mk_op(4'd0, 3'd3), mk_op(4'd1, 3'd3), mk_op(4'd3, 3'd3), mk_op(4'd5, 3'd3),
               mk_op(4'd2, 3'd3), mk_op(4'd4, 3'd3), mk_op(4'd2, 3'd3), mk_op(4'd4, 3'd3)},
             '{{32'd0, 4'b0001}, {32'd0, 4'b0000}, {32'd0, 4'b0001}, {32'd0, 4'b0001},
               {32'd0, 4'b0000}, {32'd0, 4'b0000}, {32'd0, 4'b0001}, {32'd0, 4'b0000}});
  endtask

  task automatic test_unsupported();
    run_list("unsup",
             '{32'hFFFF_FFFF, 32'd3, 32'd5, 32'd5},
             '{32'hFFFF_FFFF, 32'd4, 32'd5, 32'd5},
             '{mk_op(4'd0, 3'b111), mk_op(4'd7, 3'd0), mk_op(4'd6, 3'd3), mk_op(4'd0, 3'd1)},
             '{{32'd0, 4'b0}, {32'd0, 4'b0}, {32'd0, 4'b0}, {32'd0, 4'b0}});
  endtask

  task automatic test_latency_reset();
    logic [W+3:0] exp;
    issue(32'd100, 32'd23, mk_op(4'd0, 3'd0), {32'd123, 4'b0});
    @(posedge clk);
    #1;
    // Change inputs between edges: output must hold the previous result.
    bus.a      = 32'd1;
    bus.b      = 32'd1;
    bus.opcode = mk_op(4'd1, 3'd0);
    #2;
    exp = exp_q.pop_front();
    checks++;
    if ({bus.alu_out, bus.alu_cc} !== exp) begin
      errors++;
      $display("FAIL hold: got out=%h cc=%b, want out=%h cc=%b",
               bus.alu_out, bus.alu_cc, exp[W+3:4], exp[3:0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.alu_out !== 32'd0 || bus.alu_cc !== 4'b0000) begin
      errors++;
      $display("FAIL after_edge: got out=%h cc=%b, want 0/0000", bus.alu_out, bus.alu_cc);
    end
    // Load a nonzero result, then assert rst between edges.
    issue(32'd0, 32'd1, mk_op(4'd1, 3'd0), {32'hFFFF_FFFF, 4'b0100});
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    checks++;
    if ({bus.alu_out, bus.alu_cc} !== exp) begin
      errors++;
      $display("FAIL pre_rst: got out=%h cc=%b, want out=%h cc=%b",
               bus.alu_out, bus.alu_cc, exp[W+3:4], exp[3:0]);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.alu_out !== 32'd0 || bus.alu_cc !== 4'd0) begin
      errors++;
      $display("FAIL async_rst: got out=%h cc=%b, want 0/0000", bus.alu_out, bus.alu_cc);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.a      = 32'h7FFF_FFFF;
    bus.b      = 32'd1;
    bus.opcode = mk_op(4'd0, 3'd0);
    @(posedge clk);
    #1;
    checks++;
    if (bus.alu_out !== 32'h8000_0000 || bus.alu_cc !== 4'b0010) begin
      errors++;
      $display("FAIL post_rst: got out=%h cc=%b, want 80000000/0010", bus.alu_out, bus.alu_cc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0]  a, b;
    logic [2:0]   typ;
    logic [3:0]   func;
    logic [W+3:0] exp;
    logic [31:0]  edge_vals[4];
    edge_vals = '{32'h0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    for (int i = 0; i <= 1000; i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if ({bus.alu_out, bus.alu_cc} !== exp) begin
          errors++;
          $display("FAIL random[%0d]: got out=%h cc=%b, want out=%h cc=%b",
                   i, bus.alu_out, bus.alu_cc, exp[W+3:4], exp[3:0]);
        end
      end
      if (i < 1000) begin
        a = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
        b = ($urandom_range(0, 4) == 0) ? edge_vals[$urandom_range(0, 3)] : $urandom;
        if ($urandom_range(0, 7) == 0) b = a;
        if ($urandom_range(0, 5) == 0) typ = 3'($urandom_range(0, 7));
        else typ = $urandom_range(0, 1) ? 3'd0 : 3'd3;
        func = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
        bus.a      = a;
        bus.b      = b;
        bus.opcode = {func, typ};
        exp_q.push_back(golden(a, b, {func, typ}));
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    bus.opcode = '0;
    #2;
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_branch();
    test_unsupported();
    test_latency_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_core.md
Name: alu_core

Overview:
- 32-bit integer ALU for the RISC-Mini execute stage. Decodes a 7-bit opcode made of a function code and an instruction-type code.
- Computes arithmetic/logic results for R-type instructions and branch conditions for B-type instructions.
- Result and condition codes are registered, with one-cycle latency into the execute/writeback boundary.

Parameters:
- WIDTH, 32, operand/result width. Flag logic uses bit WIDTH-1 as the sign bit.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high; clears all outputs
- a  in  WIDTH  operand A (rs1)
- b  in  WIDTH  operand B (rs2)
- opcode  in  7  {func[3:0], type[2:0]}
- alu_out  out  WIDTH  registered result
- alu_cc  out  4  registered condition codes: [0] branch taken, [1] signed overflow, [2] borrow, [3] reserved (always 0)

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset: while rst=1, alu_out=0 and alu_cc=0 regardless of clk.
- Timing:
  - Combinational next-value logic computes from a, b and opcode.
  - Both registers load on every rising clk edge when rst=0.
  - Latency is exactly 1 cycle; there is no enable and no handshake.
  - A new operation can be issued every cycle.
- Decode: type = opcode[2:0], func = opcode[6:3].
- R_TYPE operations:
  - ADD: out=a+b mod 2^32. cc[1]=(a31&b31&~o31)|(~a31&~b31&o31). Other cc bits 0; there is no carry flag on ADD.
  - SUB: out=a-b mod 2^32. cc[1]=(a31^b31)&(a31^o31). cc[2]=unsigned(a<b). cc[0]=0.
  - MULT: out = low 32 bits of a*b (identical for signed and unsigned). cc=0.
  - AND, OR, XOR: bitwise result, cc=0.
  - NOT: out=~a, b ignored, cc=0.
- B_TYPE operations:
  - out=0 for all branch functions.
  - cc[0] = the condition; cc[3:1] = 0.
  - BEQ: a==b. BNE: a!=b.
  - BLT, BLE, BGT, BGE: signed comparisons <, <=, >, >=.
- Unsupported: any other type, or an undefined func within R/B type, gives out=0 and cc=0. No exception is raised.
- Boundaries:
  - 0x7FFFFFFF+1 sets overflow.
  - 0x80000000-1 sets overflow.
  - 0-1 gives out=0xFFFFFFFF with borrow=1.
  - Equal operands: BLE=BGE=1, BLT=BGT=0.
  - Signed compare: 0x80000000 is less than 0.
- Reset mid-operation: asserting rst clears outputs immediately. After rst deasserts, the first rising clk edge loads the current inputs' result.

Decomposition:
- Package alu_pkg holds:
  - TYPE codes: R_TYPE=3'b000, I_TYPE=3'b001, M_TYPE=3'b010, B_TYPE=3'b011, J_TYPE=3'b100.
  - R func codes: ADD=0, SUB=1, MULT=2, AND=3, OR=4, XOR=5, NOT=6.
  - B func codes: BEQ=0, BNE=1, BLT=2, BLE=3, BGT=4, BGE=5.
  - CC bit index constants: CC_TAKEN=0, CC_OVF=1, CC_BORROW=2.
- The existing opcodes.vh macros must match these values.
- One sub-module, alu_comb: purely combinational datapath producing next out/cc. alu_core wraps it with the output register.

Test Plan:
- ADD, normal and overflow:
  - rst pulse, then a=5, b=7, ADD, one clk -> out=12, cc=0000.
  - a=0x7FFFFFFF, b=1, ADD -> out=0x80000000, cc=0010.
- SUB borrow and overflow:
  - a=0, b=1 -> out=0xFFFFFFFF, cc=0100.
  - a=0x80000000, b=1 -> out=0x7FFFFFFF, cc=0010.
  - a=9, b=4 -> out=5, cc=0000.
- MULT and logic, a=0x12345678, b=0x0F0F0F0F:
  - AND -> out=0x02040608.
  - OR -> out=0x1F3F5F7F.
  - XOR -> out=0x1D3B5977.
  - NOT -> out=0xEDCBA987.
  - MULT a=0xFFFFFFFF, b=2 -> out=0xFFFFFFFE.
  - All cc=0.
- Branches:
  - a=b=0x1234 -> BEQ=1, BNE=0, BLE=1, BGE=1, BLT=0, BGT=0.
  - a=0x80000000, b=0 -> BLT=1, BGT=0.
  - out=0 in every case.
- Latency and reset:
  - Change inputs, check outputs hold until the next rising clk edge.
  - Assert rst between edges -> out=0, cc=0 immediately.
  - opcode with type=3'b111 -> out=0, cc=0.
- Random regression: 1000 random a/b across all opcodes, checked against a golden model delayed by one cycle.
